clk_div_ctrl: RTL and testbench

Run-time controller for the team's half-period toggle clock divider. It owns the divide counter and sequences start, stop and divisor changes so that `clk_out` never glitches and never produces a short high phase. Software or a parent FSM supplies new divisors through a valid/ready handshake. It sits between the configuration logic and every consumer of the divided clock or its `tick` strobe.

---
 rtl/clk_div_ctrl.sv | 79 +++++++
 tb/tb_clk_div_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time controller for a half-period toggle clock divider.
// Sequences start, stop and divisor changes so clk_out never glitches or shortens a high phase.
module clk_div_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 12
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);
  typedef enum logic [1:0] {STOP, RUN, PEND, DRAIN} state_t;
  state_t           state;
  logic [CNT_W-1:0] counter, pend_half, next_half;
  logic             pend, xfer, ok, toggle, fall, next_pend;
  assign cfg_ready = !pend;
  assign running   = state != STOP;
  assign xfer      = cfg_valid && cfg_ready;
  assign ok        = xfer && cfg_half != '0;
  assign toggle    = running && counter == cur_half - 1'b1;
  assign fall      = toggle && clk_out;
  // A value accepted in the same cycle that DRAIN stops is applied straight away
  assign next_pend = pend || ok;
  assign next_half = pend ? pend_half : cfg_half;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state     <= STOP;
      counter   <= '0;
      cur_half  <= CNT_W'(DEFAULT_HALF);
      pend_half <= '0;
      pend      <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= xfer && cfg_half == '0;
      counter <= toggle ? '0 : running ? counter + 1'b1 : '0;
      clk_out <= running && (clk_out ^ toggle);
      tick    <= toggle && !clk_out;
      if (ok && running) begin
        pend_half <= cfg_half;
        pend      <= 1'b1;
      end
      case (state)
        STOP: begin
          if (ok) cur_half <= cfg_half;
          if (en) state <= RUN;
        end
        RUN: state <= !en ? DRAIN : ok ? PEND : RUN;
        PEND: begin
          if (!en) state <= DRAIN;
          else if (fall) begin
            cur_half <= pend_half;
            pend     <= 1'b0;
            state    <= RUN;
          end
        end
        DRAIN: begin
          if (en) state <= next_pend ? PEND : RUN;
          else if (!clk_out || fall) begin
            state   <= STOP;
            counter <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
            if (next_pend) cur_half <= next_half;
          end
        end
        default: state <= STOP;
      endcase
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed test-plan scenarios plus random en/config traffic,
// checked every cycle against a phase-duration reference model.
module tb_clk_div_ctrl;
  localparam int CNT_W = 16;
  logic             clk_in = 1'b0, reset = 1'b0, en = 1'b0, cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready, cfg_err, clk_out, tick, running;
  logic [CNT_W-1:0] cur_half;
  int n_tests = 0, n_fail = 0, n;
  bit m_on, m_drain, m_lvl, m_tick, m_err;
  int m_age, m_half;
  int q[$];

  clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_HALF(12)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .running(running), .cur_half(cur_half)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_drain = 0; m_lvl = 0; m_tick = 0; m_err = 0; m_age = 0; m_half = 12;
    q.delete();
  endtask

  // Model: a phase lasts m_half cycles; queued halves wait for the end of a high phase
  task automatic model_step();
    bit xfer, good, had, flip, fell, old;
    xfer   = cfg_valid && q.size() == 0;
    m_err  = xfer && cfg_half == '0;
    good   = xfer && cfg_half != '0;
    had    = q.size() != 0;
    m_tick = 0;
    if (!m_on) begin
      if (good) m_half = int'(cfg_half);
      if (en) begin m_on = 1; m_drain = 0; end
    end else begin
      old    = m_lvl;
      flip   = m_age + 1 == m_half;
      fell   = flip && old;
      m_tick = flip && !old;
      m_lvl  = old ^ flip;
      m_age  = flip ? 0 : m_age + 1;
      if (good) q.push_back(int'(cfg_half));
      if (!m_drain) begin
        if (!en) m_drain = 1;
        else if (fell && had) m_half = q.pop_front();
      end else if (en) m_drain = 0;
      else if (!old || fell) begin
        m_on = 0; m_lvl = 0; m_age = 0; m_tick = 0;
        if (q.size() != 0) m_half = q.pop_front();
      end
    end
  endtask

  task automatic check_all();
    chk("clk_out", int'(clk_out), int'(m_lvl));
    chk("tick", int'(tick), int'(m_tick));
    chk("cfg_err", int'(cfg_err), int'(m_err));
    chk("running", int'(running), int'(m_on));
    chk("cfg_ready", int'(cfg_ready), int'(q.size() == 0));
    chk("cur_half", int'(cur_half), m_half);
  endtask

  task automatic step();
    @(posedge clk_in);
    if (reset) model_step();
    #1;
    check_all();
  endtask

  task automatic until_tick(output int k);
    k = 0;
    do begin step(); k++; end while (!tick && k < 200);
  endtask

  task automatic xfer1(input int h);
    cfg_valid = 1'b1; cfg_half = CNT_W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_half", int'(cur_half), 12);
    chk("rst_ready", int'(cfg_ready), 1);
    reset = 1'b1;
    // start and steady period
    en = 1'b1;
    step();
    until_tick(n);
    chk("first_rise", n, 12);
    until_tick(n);
    chk("period24", n, 24);
    chk("run_flag", int'(running), 1);
    // change to 3 in the middle of a high phase
    step(); step();
    xfer1(3);
    chk("busy", int'(cfg_ready), 0);
    n = 3;
    do begin step(); n++; end while (clk_out && n < 100);
    chk("high_kept", n, 12);
    until_tick(n);
    until_tick(n);
    chk("period6", n, 6);
    chk("half3", int'(cur_half), 3);
    chk("ready_back", int'(cfg_ready), 1);
    // zero divisor is rejected
    xfer1(0);
    chk("err_pulse", int'(cfg_err), 1);
    chk("err_ready", int'(cfg_ready), 1);
    step();
    chk("err_clear", int'(cfg_err), 0);
    chk("err_half", int'(cur_half), 3);
    until_tick(n);
    until_tick(n);
    chk("period_kept", n, 6);
    // back to 12, then stop 4 cycles into a high phase
    xfer1(12);
    n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    chk("ready_wait", int'(cfg_ready), 1);
    until_tick(n);
    step(); step(); step();
    en = 1'b0;
    step();
    n = 0;
    do begin step(); n++; end while (clk_out && n < 100);
    chk("drain_high", n, 8);
    chk("drain_stop", int'(running), 0);
    // stop during a low phase
    en = 1'b1;
    step(); step(); step();
    en = 1'b0;
    step();
    chk("drain_run", int'(running), 1);
    step();
    chk("low_stop", int'(running), 0);
    chk("low_clk", int'(clk_out), 0);
    // divide by 2
    xfer1(1);
    chk("half1", int'(cur_half), 1);
    en = 1'b1;
    step();
    until_tick(n);
    until_tick(n);
    chk("fast_period", n, 2);
    // reset in a high phase with a pending value
    en = 1'b0;
    n = 0;
    while (running && n < 50) begin step(); n++; end
    xfer1(12);
    en = 1'b1;
    step();
    until_tick(n);
    step(); step();
    xfer1(5);
    chk("pend_busy", int'(cfg_ready), 0);
    #3 reset = 1'b0;
    #1;
    chk("async_low", int'(clk_out), 0);
    model_reset();
    check_all();
    en = 1'b0;
    step();
    reset = 1'b1;
    chk("rel_half", int'(cur_half), 12);
    chk("rel_ready", int'(cfg_ready), 1);
    step();
    chk("rel_stop", int'(running), 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      cfg_valid = $urandom_range(0, 7) == 0;
      cfg_half = CNT_W'($urandom_range(0, 6));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
